// File: rtl/free_list_ctrl.sv
// -----------------------------------------------------------------------------
// free_list_ctrl
//   Physical-register free list for a 3-wide R10K-style rename stage.
//   Offers up to three free PR tags per cycle to the map table, reclaims Told
//   tags from the ROB at retire, and restores the full free pool on a branch
//   mispredict, in step with the arch map table copy-back.
//
// Ports
//   clock            in   posedge clock
//   reset            in   synchronous, active-high
//   i_dispatch_num   in   PRs consumed this cycle (0..3); pop is clamped to o_avail_num
//   i_retire_num     in   Told tags returned this cycle (0..3)
//   i_retire_told    in   returned tags; slot 2 is the oldest, valid slots 2..3-i_retire_num
//   i_bp_recover_en  in   mispredict recovery pulse
//   o_alloc_pr       out  offered tags; slot 2 = head, slot 1 = head+1, slot 0 = head+2
//   o_avail_num      out  min(free count, 3)
//   o_free_count     out  number of free entries
//
// Build option
//   FREE_LIST_DEBUG_EN : adds o_fl_array_disp, o_head_disp, o_tail_disp and a
//                        sticky o_fl_error. Functional behaviour is unchanged.
// -----------------------------------------------------------------------------
module free_list_ctrl #(
  parameter  int PR_W    = 6,
  parameter  int NUM_AR  = 32,
  localparam int NUM_PR  = 1 << PR_W,
  localparam int FL_SIZE = NUM_PR - NUM_AR,
  localparam int CNT_W   = $clog2(FL_SIZE + 1),
  localparam int PTR_W   = $clog2(FL_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [1:0]                 i_dispatch_num,
  input  logic [1:0]                 i_retire_num,
  input  logic [2:0][PR_W-1:0]       i_retire_told,
  input  logic                       i_bp_recover_en,
  output logic [2:0][PR_W-1:0]       o_alloc_pr,
  output logic [1:0]                 o_avail_num,
  output logic [CNT_W-1:0]           o_free_count
`ifdef FREE_LIST_DEBUG_EN
  ,
  output logic [FL_SIZE-1:0][PR_W-1:0] o_fl_array_disp,
  output logic [PTR_W-1:0]           o_head_disp,
  output logic [PTR_W-1:0]           o_tail_disp,
  output logic                       o_fl_error
`endif
);

  // Pointer advance modulo FL_SIZE (FL_SIZE need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [1:0]       n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(FL_SIZE)) s = s - (PTR_W+1)'(FL_SIZE);
    return s[PTR_W-1:0];
  endfunction

  logic [PR_W-1:0]  r_fl [FL_SIZE];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic [1:0]       w_avail;
  logic [1:0]       w_disp_eff;
  logic [PTR_W-1:0] w_head_next;
  logic [PTR_W-1:0] w_tail_next;
  logic [CNT_W-1:0] w_count_next;

  // Outputs depend only on registered state; retired tags appear next cycle.
  always_comb begin
    w_avail       = (r_count >= CNT_W'(3)) ? 2'd3 : r_count[1:0];
    o_avail_num   = w_avail;
    o_free_count  = r_count;
    o_alloc_pr[2] = r_fl[r_head];
    o_alloc_pr[1] = r_fl[ptr_add(r_head, 2'd1)];
    o_alloc_pr[0] = r_fl[ptr_add(r_head, 2'd2)];
  end

  // An over-request is clamped so head can never run past tail.
  always_comb begin
    w_disp_eff  = (i_dispatch_num > w_avail) ? w_avail : i_dispatch_num;
    w_tail_next = ptr_add(r_tail, i_retire_num);
    if (i_bp_recover_en) begin
      // Squashed allocations are still in storage between tail and old head,
      // so the whole ring becomes free again starting at the new tail.
      w_head_next  = w_tail_next;
      w_count_next = CNT_W'(FL_SIZE);
    end else begin
      w_head_next  = ptr_add(r_head, w_disp_eff);
      w_count_next = r_count - CNT_W'(w_disp_eff) + CNT_W'(i_retire_num);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the tag storage itself is reset here because the initial free
      // pool contents (PR NUM_AR..NUM_PR-1) are architecturally visible.
      for (int i = 0; i < FL_SIZE; i++) r_fl[i] <= PR_W'(NUM_AR + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(FL_SIZE);
    end else begin
      for (int j = 0; j < 3; j++) begin
        if (j < int'(i_retire_num)) r_fl[ptr_add(r_tail, 2'(j))] <= i_retire_told[2-j];
      end
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

`ifdef FREE_LIST_DEBUG_EN
  logic r_fl_error;
  logic r_retired_once;
  logic w_err;

  always_comb begin
    for (int i = 0; i < FL_SIZE; i++) o_fl_array_disp[i] = r_fl[i];
    o_head_disp = r_head;
    o_tail_disp = r_tail;
    o_fl_error  = r_fl_error;

    w_err = 1'b0;
    if (i_dispatch_num > w_avail) w_err = 1'b1;
    if (int'(r_count) + int'(i_retire_num) - int'(i_dispatch_num) > FL_SIZE) w_err = 1'b1;
    // Only the very first retire is screened for architectural-range tags.
    if (!r_retired_once) begin
      for (int j = 0; j < 3; j++) begin
        if (j < int'(i_retire_num) && int'(i_retire_told[2-j]) < NUM_AR) w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fl_error     <= 1'b0;
      r_retired_once <= 1'b0;
    end else begin
      r_fl_error     <= r_fl_error | w_err;
      r_retired_once <= r_retired_once | (i_retire_num != 2'd0);
    end
  end
`endif

endmodule

// File: tb/tb_free_list_ctrl.sv
// -----------------------------------------------------------------------------
// tb_free_list_ctrl
//   Reference model: the free pool is a queue of tags in allocation order, and
//   a second queue holds tags handed out whose storage slots have not yet been
//   reused by a retire. Retire reuses the oldest such slot; recovery puts those
//   tags back in front of the free queue.
// -----------------------------------------------------------------------------
module tb_free_list_ctrl;
  localparam int PR_W    = 6;
  localparam int NUM_AR  = 32;
  localparam int FL_SIZE = (1 << PR_W) - NUM_AR;
  localparam int CNT_W   = $clog2(FL_SIZE + 1);
  localparam int PTR_W   = $clog2(FL_SIZE);

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           dispatch_num;
  logic [1:0]           retire_num;
  logic [2:0][PR_W-1:0] retire_told;
  logic                 bp_recover_en;
  logic [2:0][PR_W-1:0] alloc_pr;
  logic [1:0]           avail_num;
  logic [CNT_W-1:0]     free_count;
`ifdef FREE_LIST_DEBUG_EN
  logic [FL_SIZE-1:0][PR_W-1:0] fl_array_disp;
  logic [PTR_W-1:0]     head_disp;
  logic [PTR_W-1:0]     tail_disp;
  logic                 fl_error;
`endif

  free_list_ctrl #(.PR_W(PR_W), .NUM_AR(NUM_AR)) dut (
    .clock           (clock),
    .reset           (reset),
    .i_dispatch_num  (dispatch_num),
    .i_retire_num    (retire_num),
    .i_retire_told   (retire_told),
    .i_bp_recover_en (bp_recover_en),
    .o_alloc_pr      (alloc_pr),
    .o_avail_num     (avail_num),
    .o_free_count    (free_count)
`ifdef FREE_LIST_DEBUG_EN
    ,
    .o_fl_array_disp (fl_array_disp),
    .o_head_disp     (head_disp),
    .o_tail_disp     (tail_disp),
    .o_fl_error      (fl_error)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int m_free[$];
  int m_infl[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int min3(input int a);
    return (a > 3) ? 3 : a;
  endfunction

  task automatic model_update(input int d, input int r, input int t[3],
                              input bit rec, input bit rst);
    int dd;
    int keep[$];
    if (rst) begin
      m_free = {};
      m_infl = {};
      for (int i = 0; i < FL_SIZE; i++) m_free.push_back(NUM_AR + i);
    end else begin
      if (!rec) begin
        dd = (d > min3(m_free.size())) ? min3(m_free.size()) : d;
        for (int i = 0; i < dd; i++) m_infl.push_back(m_free.pop_front());
      end
      for (int j = 0; j < r; j++) begin
        if (m_infl.size() > 0) void'(m_infl.pop_front());
        m_free.push_back(t[j]);
      end
      if (rec) begin
        keep = m_infl;
        foreach (m_free[i]) keep.push_back(m_free[i]);
        m_free = keep;
        m_infl = {};
      end
    end
  endtask

  task automatic check_outputs();
    check("free_count", 32'(free_count), 32'(m_free.size()));
    check("avail_num", 32'(avail_num), 32'(min3(m_free.size())));
    for (int k = 0; k < 3; k++) begin
      if (k < m_free.size())
        check($sformatf("alloc_pr[%0d]", 2 - k), 32'(alloc_pr[2-k]), 32'(m_free[k]));
    end
  endtask

  // One clock of stimulus; outputs are compared 1 time unit after the edge.
  task automatic step(input int d, input int r, input int t2, input int t1, input int t0,
                      input bit rec, input bit rst);
    int t[3];
    t = '{t2, t1, t0};
    reset          = rst;
    dispatch_num   = 2'(d);
    retire_num     = 2'(r);
    retire_told[2] = PR_W'(t2);
    retire_told[1] = PR_W'(t1);
    retire_told[0] = PR_W'(t0);
    bp_recover_en  = rec;
    @(posedge clock);
    model_update(d, r, t, rec, rst);
    #1;
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_alloc2"}, 32'(alloc_pr[2]), 32);
    check({tag, "_alloc1"}, 32'(alloc_pr[1]), 33);
    check({tag, "_alloc0"}, 32'(alloc_pr[0]), 34);
    check({tag, "_avail"}, 32'(avail_num), 3);
    check({tag, "_count"}, 32'(free_count), 32);
  endtask

  task automatic random_steps(input int n);
    int d, r, lim;
    bit rec;
    for (int i = 0; i < n; i++) begin
      rec = ($urandom_range(0, 19) == 0);
      d   = $urandom_range(0, 3);
      lim = rec ? m_infl.size()
                : m_infl.size() + ((d > min3(m_free.size())) ? min3(m_free.size()) : d);
      r   = $urandom_range(0, min3(lim));
      step(d, r, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
           rec, ($urandom_range(0, 99) == 0));
    end
  endtask

  initial begin
    // Scenario 1: reset state.
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    check_reset_values("rst");

    // Scenario 2: ten full-width dispatches.
    for (int i = 0; i < 10; i++) step(3, 0, 0, 0, 0, 1'b0, 1'b0);
    check("s2_count", 32'(free_count), 2);
    check("s2_avail", 32'(avail_num), 2);
    check("s2_alloc2", 32'(alloc_pr[2]), 62);
    check("s2_alloc1", 32'(alloc_pr[1]), 63);

    // Scenario 4: count 3 with head at entry 30, steady dispatch 3 + retire 3.
    step(0, 1, 40, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(3, 3, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63),
           1'b0, 1'b0);
      check("s4_count", 32'(free_count), 3);
    end

    // Scenario 3: drain to empty, then retire two tags.
    step(3, 0, 0, 0, 0, 1'b0, 1'b0);
    check("s3_empty_avail", 32'(avail_num), 0);
    step(0, 2, 5, 7, 0, 1'b0, 1'b0);
    check("s3_avail", 32'(avail_num), 2);
    check("s3_alloc2", 32'(alloc_pr[2]), 5);
    check("s3_alloc1", 32'(alloc_pr[1]), 7);

    // Scenario 5: recovery after 9 allocations, dispatch ignored in that cycle.
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(3, 0, 0, 0, 0, 1'b0, 1'b0);
    step(3, 0, 0, 0, 0, 1'b1, 1'b0);
    check("s5_count", 32'(free_count), 32);
    check("s5_alloc2", 32'(alloc_pr[2]), 32);
    step(0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(3, 0, 0, 0, 0, 1'b0, 1'b0);
    step(0, 1, 9, 0, 0, 1'b1, 1'b0);
    check("s5r_count", 32'(free_count), 32);
    check("s5r_alloc2", 32'(alloc_pr[2]), 33);

    // Randomized traffic, including over-requests, recoveries and resets.
    random_steps(400);

    // Scenario 6: reset mid-stream with heavy traffic on the inputs.
    random_steps(10);
    step(3, 3, 1, 2, 3, 1'b1, 1'b1);
    check_reset_values("s6");

`ifdef FREE_LIST_DEBUG_EN
    check("dbg_err_clear", 32'(fl_error), 0);
    for (int i = 0; i < 10; i++) step(3, 0, 0, 0, 0, 1'b0, 1'b0);
    step(1, 0, 0, 0, 0, 1'b0, 1'b0);
    check("dbg_err_before", 32'(fl_error), 0);
    step(3, 0, 0, 0, 0, 1'b0, 1'b0);
    check("dbg_err_set", 32'(fl_error), 1);
    step(0, 0, 0, 0, 0, 1'b0, 1'b0);
    check("dbg_err_sticky", 32'(fl_error), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
